// File: rtl/xor_stream_descrambler.sv
// Receive-side XOR byte descrambler. Each accepted byte is XORed with an
// 8-bit Galois-LFSR keystream and presented through one registered output
// stage with valid/ready on both sides. Also counts recovered bytes.
module xor_stream_descrambler #(
   parameter int unsigned       WIDTH = 8,
   parameter logic [WIDTH-1:0]  POLY  = 8'hB8,
   parameter logic [WIDTH-1:0]  SEED  = 8'h01
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [15:0]      byte_count
);

   logic [WIDTH-1:0] key_q, key_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [15:0]      count_q, count_d;
   logic [WIDTH-1:0] key_step;
   logic             accept;

   // Ready only when the output slot is free or draining; reset and seed
   // reload both block new input.
   assign in_ready = reset_n && (!valid_q || out_ready) && !seed_load;
   assign accept   = in_valid && in_ready;

   // One right-shift Galois step; a nonzero key never steps to zero.
   assign key_step = key_q[0] ? ((key_q >> 1) ^ POLY) : (key_q >> 1);

   // Next-state: seed reload beats accept, accept beats drain, else hold.
   always_comb begin
      key_d   = key_q;
      data_d  = data_q;
      valid_d = valid_q;
      count_d = count_q;
      if (seed_load) begin
         key_d   = (seed_in == '0) ? SEED : seed_in;
         count_d = 16'd0;
         valid_d = 1'b0;
      end else if (accept) begin
         data_d  = in_data ^ key_q;
         valid_d = 1'b1;
         key_d   = key_step;
         count_d = count_q + 16'd1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_q   <= SEED;
         data_q  <= '0;
         valid_q <= 1'b0;
         count_q <= 16'd0;
      end else begin
         key_q   <= key_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_data   = data_q;
   assign byte_count = count_q;

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Self-checking bench for xor_stream_descrambler: directed test-plan steps
// followed by a randomized stream, all checked against a keystream-index model.
module tb_xor_stream_descrambler;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       seed_load;
   logic [7:0] seed_in;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [15:0] byte_count;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: keystream position since the last seed, not an LFSR register.
   logic [7:0]  m_seed;
   int          m_idx;
   logic [15:0] m_cnt;
   logic        m_valid;
   logic [7:0]  m_data;

   xor_stream_descrambler #(
      .WIDTH(8),
      .POLY (8'hB8),
      .SEED (8'h01)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .byte_count(byte_count)
   );

   always #5 clk = ~clk;

   // n-th keystream byte after starting from seed s.
   function automatic logic [7:0] ks(input logic [7:0] s, input int n);
      logic [7:0] k;
      k = s;
      for (int i = 0; i < n; i++) k = k[0] ? ((k >> 1) ^ 8'hB8) : (k >> 1);
      return k;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_seed  = 8'h01;
      m_idx   = 0;
      m_cnt   = 16'd0;
      m_valid = 1'b0;
      m_data  = 8'h00;
   endtask

   // Check in_ready for the current inputs, apply one edge to the model and
   // the DUT, then check the registered outputs.
   task automatic cycle();
      logic exp_rdy;
      #1;
      exp_rdy = (!m_valid || out_ready) && !seed_load;
      chk("in_ready", {15'd0, in_ready}, {15'd0, exp_rdy});
      if (seed_load) begin
         m_seed  = (seed_in == 8'h00) ? 8'h01 : seed_in;
         m_idx   = 0;
         m_cnt   = 16'd0;
         m_valid = 1'b0;
      end else if (in_valid && exp_rdy) begin
         m_data  = in_data ^ ks(m_seed, m_idx);
         m_idx   = (m_idx + 1) % 255;
         m_cnt   = m_cnt + 16'd1;
         m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
      chk("out_data", {8'd0, out_data}, {8'd0, m_data});
      chk("byte_count", byte_count, m_cnt);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic rdy);
      seed_load = 1'b0;
      in_valid  = v;
      in_data   = v ? d : 8'hxx;
      out_ready = rdy;
   endtask

   task automatic reload(input logic [7:0] s);
      seed_load = 1'b1;
      seed_in   = s;
      in_valid  = 1'b0;
      cycle();
      seed_load = 1'b0;
   endtask

   initial begin
      // Reset state
      reset_n   = 1'b0;
      seed_load = 1'b0;
      seed_in   = 8'h00;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      model_reset();
      #12;
      chk("rst_valid", {15'd0, out_valid}, 16'd0);
      chk("rst_data", {8'd0, out_data}, 16'd0);
      chk("rst_count", byte_count, 16'd0);
      chk("rst_ready", {15'd0, in_ready}, 16'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Stream 55, 50, 00 -> 54, E8, 5C
      drive(1'b1, 8'h55, 1'b1); cycle(); chk("tp1_b0", {8'd0, out_data}, 16'h0054);
      drive(1'b1, 8'h50, 1'b1); cycle(); chk("tp1_b1", {8'd0, out_data}, 16'h00E8);
      drive(1'b1, 8'h00, 1'b1); cycle(); chk("tp1_b2", {8'd0, out_data}, 16'h005C);
      chk("tp1_count", byte_count, 16'd3);
      drive(1'b0, 8'h00, 1'b1); cycle();

      // Backpressure
      reload(8'h01);
      drive(1'b1, 8'h55, 1'b0); cycle(); chk("bp_first", {8'd0, out_data}, 16'h0054);
      drive(1'b1, 8'h50, 1'b0); cycle();
      cycle();
      chk("bp_hold_count", byte_count, 16'd1);
      drive(1'b1, 8'h50, 1'b1); cycle(); chk("bp_release", {8'd0, out_data}, 16'h00E8);
      drive(1'b0, 8'h00, 1'b1); cycle();

      // Seed reload mid-stream with a pending byte
      drive(1'b1, 8'hA5, 1'b0); cycle();
      reload(8'h17);
      chk("reload_count", byte_count, 16'd0);
      drive(1'b1, 8'h00, 1'b1); cycle(); chk("reload_b0", {8'd0, out_data}, 16'h0017);
      drive(1'b1, 8'h00, 1'b1); cycle(); chk("reload_b1", {8'd0, out_data}, 16'h00B3);

      // Zero seed substitutes SEED
      reload(8'h00);
      drive(1'b1, 8'h00, 1'b1); cycle(); chk("zero_seed", {8'd0, out_data}, 16'h0001);

      // seed_load coincident with in_valid
      seed_load = 1'b1; seed_in = 8'h2E; in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
      cycle();
      drive(1'b1, 8'h00, 1'b1); cycle(); chk("coinc_next", {8'd0, out_data}, 16'h002E);

      // Async reset between edges while a byte is pending
      drive(1'b1, 8'h33, 1'b0); cycle();
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("arst_valid", {15'd0, out_valid}, 16'd0);
      chk("arst_count", byte_count, 16'd0);
      chk("arst_data", {8'd0, out_data}, 16'd0);
      chk("arst_ready", {15'd0, in_ready}, 16'd0);
      #1;
      reset_n = 1'b1;
      drive(1'b1, 8'h55, 1'b1); cycle(); chk("arst_after", {8'd0, out_data}, 16'h0054);

      // Randomized traffic with stalls, bubbles and occasional reloads
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
         if ($urandom_range(0, 39) == 0) begin
            seed_load = 1'b1;
            seed_in   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/xor_stream_descrambler.md
Name: xor_stream_descrambler

Overview:
- Receive side of the team's XOR byte-scrambling link: recovers plaintext bytes by XORing each incoming scrambled byte with an 8-bit Galois-LFSR keystream.
- The keystream matches the transmit-side scrambler byte-for-byte when both sides use the same seed.
- Sits between the link input and the consumer, with valid/ready handshakes on both sides and one registered output stage.
- Also tracks a count of recovered bytes.

Parameters:
- WIDTH, 8, data and keystream width in bits; the LFSR logic is defined for 8.
- POLY, 8'hB8, Galois feedback mask (x^8+x^6+x^5+x^4+1, maximal length 255).
- SEED, 8'h01, keystream value after reset; also substituted for an illegal zero seed.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- seed_load  input  1  load seed_in into keystream and clear byte_count
- seed_in  input  WIDTH  new keystream seed
- in_valid  input  1  scrambled byte present on in_data
- in_ready  output  1  block can accept in_data this cycle
- in_data  input  WIDTH  scrambled byte
- out_valid  output  1  recovered byte present on out_data
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  WIDTH  recovered (descrambled) byte
- byte_count  output  16  number of bytes accepted since reset or the last seed_load

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-low (reset_n). It is asserted immediately and released synchronously to clk.
- Reset values: key=SEED, out_valid=0, out_data=0, byte_count=0.
- in_ready is combinational: (!out_valid || out_ready) && !seed_load. It is 0 while reset_n=0.
- Accept occurs when in_valid && in_ready at a rising edge. On accept:
  - out_data <= in_data ^ key.
  - out_valid <= 1.
  - The key advances one step.
  - byte_count increments.
  - Latency is 1 cycle from accept to out_valid.
- Key step (Galois, right shift): next = key[0] ? ((key>>1) ^ POLY) : (key>>1). The key advances only on accept, never on stalls.
- Sequence from 8'h01: 01, B8, 5C, 2E, 17, B3, ...
- Output drain: when out_valid && out_ready and there is no new accept, out_valid <= 0. out_data holds its last value.
- Simultaneous drain and accept: out_valid stays 1 and out_data takes the new byte. This sustains full throughput of 1 byte/cycle.
- Backpressure: when out_valid=1 and out_ready=0:
  - in_ready=0.
  - out_data, out_valid, key and byte_count hold.
- seed_load=1 at an edge:
  - key <= (seed_in==0) ? SEED : seed_in.
  - byte_count <= 0.
  - out_valid <= 0, discarding any undelivered byte.
  - No accept occurs that cycle, because in_ready is forced low.
  - seed_load has priority over every other event.
- byte_count wraps from 16'hFFFF to 0 with no flag.
- The key can never reach 0 under any stimulus.
- reset_n asserted mid-stream returns every register to its reset value immediately. A pending output byte is lost.
- X on in_data is permitted when in_valid=0 and must not affect state.

Test Plan:
- Reset then stream: seed 01, send 55, 50, 00 with out_ready=1 -> out_data 54, E8, 5C on consecutive cycles; byte_count=3.
- Backpressure:
  - Hold out_ready=0 and send 55 -> out_valid=1 with 54, and in_ready=0.
  - The second byte 50 stays offered with no accept; key and count are unchanged.
  - Raise out_ready -> 50 is accepted and E8 appears the next cycle.
- Seed reload: after 3 bytes, pulse seed_load with seed_in=17 -> count=0 and out_valid=0. Then send 00, 00 -> out 17, B3.
- Zero seed: seed_load with seed_in=00, then send 00 -> out 01 (SEED substituted).
- seed_load coincident with in_valid=1 -> in_ready=0, byte not accepted, key=seed_in. The byte is accepted on the next cycle using the new seed.
- Async reset mid-stream: assert reset_n=0 between edges while out_valid=1 -> out_valid=0, byte_count=0 immediately. After release, input 55 -> 54.
